// File: rtl/l4_status_regfile_if.sv
// Control/status bus between the switch controller and the status register file.
// Pure wiring: no storage, no added latency.
// Backpressure: the change offer holds until chg_ack; load/set_empty are never stalled.
interface l4_status_regfile_if #(
    parameter int NBITS = 4,
    parameter int NCH   = 4,
    parameter int CHW   = 2
);
    logic [NCH-1:0]       set_empty;
    logic                 ld_en;
    logic [CHW-1:0]       ld_ch;
    logic [NBITS-1:0]     ld_d;
    logic [CHW-1:0]       rd_ch;
    logic [NBITS-1:0]     rd_q;
    logic [NCH*NBITS-1:0] q_all;
    logic                 chg_valid;
    logic [CHW-1:0]       chg_ch;
    logic                 chg_ack;

    // Controller side
    modport master (
        output set_empty, ld_en, ld_ch, ld_d, rd_ch, chg_ack,
        input  rd_q, q_all, chg_valid, chg_ch
    );

    // Register file side
    modport slave (
        input  set_empty, ld_en, ld_ch, ld_d, rd_ch, chg_ack,
        output rd_q, q_all, chg_valid, chg_ch
    );
endinterface

// File: rtl/l4_status_regfile.sv
// Per-channel status words with force-to-empty, addressed load and round-robin change reporting.
// Latency: words and rd_q visible 1 cycle after the strobe; first change offer 2 edges after the update.
// Backpressure: an offer holds chg_valid/chg_ch until chg_ack; one IDLE bubble follows each ack.
module l4_status_regfile #(
    parameter int               NBITS     = 4,
    parameter int               NCH       = 4,
    parameter int               CHW       = 2,
    parameter logic [NBITS-1:0] EMPTY_VAL = NBITS'(1)
) (
    input  logic                clk,
    input  logic                reset,
    l4_status_regfile_if.slave  bus
);
    typedef enum logic {IDLE, OFFER} state_t;

    logic [NBITS-1:0] word_q [NCH];
    logic [NBITS-1:0] word_d [NCH];
    logic [NCH-1:0]   chg_set;
    logic [NCH-1:0]   flag_clr;
    logic [NCH-1:0]   flag_q;
    logic [NCH-1:0]   flag_d;
    logic [NBITS-1:0] rd_q;
    logic [NBITS-1:0] rd_d;
    state_t           state_q;
    state_t           state_d;
    logic [CHW-1:0]   ptr_q;
    logic [CHW-1:0]   ptr_d;
    logic [CHW-1:0]   ch_q;
    logic [CHW-1:0]   ch_d;
    logic             found;
    logic [CHW-1:0]   pick;

    // Next word value per channel (set_empty beats load) and whether it differs from the current one
    always_comb begin
        chg_set = '0;
        for (int i = 0; i < NCH; i++) begin
            word_d[i] = word_q[i];
            if (bus.set_empty[i]) begin
                word_d[i] = EMPTY_VAL;
            end else if (bus.ld_en && (bus.ld_ch == CHW'(i))) begin
                word_d[i] = bus.ld_d;
            end
            chg_set[i] = (word_d[i] != word_q[i]);
        end
    end

    // Read mux on pre-update words; out-of-range channels read as zero
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.rd_ch == CHW'(i)) begin
                rd_d = word_q[i];
            end
        end
    end

    // First set change flag at or after ptr, wrapping modulo NCH
    always_comb begin
        int             j;
        logic [CHW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            cand = CHW'(j);
            if (!found && flag_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Reporter FSM next state; ack clears the offered flag and moves ptr past it
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        ptr_d    = ptr_q;
        flag_clr = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OFFER;
                    ch_d    = pick;
                end
            end
            OFFER: begin
                if (bus.chg_ack) begin
                    state_d        = IDLE;
                    flag_clr[ch_q] = 1'b1;
                    ptr_d          = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A change in the ack cycle re-sets the flag being cleared
    assign flag_d = (flag_q & ~flag_clr) | chg_set;

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                word_q[i] <= '0;
            end
            flag_q  <= '0;
            rd_q    <= '0;
            state_q <= IDLE;
            ptr_q   <= '0;
            ch_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                word_q[i] <= word_d[i];
            end
            flag_q  <= flag_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_qall
        assign bus.q_all[g*NBITS +: NBITS] = word_q[g];
    end

    assign bus.rd_q      = rd_q;
    assign bus.chg_valid = (state_q == OFFER);
    assign bus.chg_ch    = ch_q;
endmodule

// File: tb/tb_l4_status_regfile.sv
// Self-checking bench for l4_status_regfile: vector table plus offer-order scoreboard sequences.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Offers are held one cycle before ack to observe that chg_valid/chg_ch stay stable.
module tb_l4_status_regfile;
    localparam int NBITS = 4;
    localparam int NCH   = 4;
    localparam int CHW   = 2;

    logic clk;
    logic reset;

    l4_status_regfile_if #(.NBITS(NBITS), .NCH(NCH), .CHW(CHW)) bus ();

    l4_status_regfile #(
        .NBITS(NBITS), .NCH(NCH), .CHW(CHW), .EMPTY_VAL(4'h1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  se;
        logic        ld_en;
        logic [1:0]  ld_ch;
        logic [3:0]  ld_d;
        logic [1:0]  rd_ch;
        logic        ack;
        logic [15:0] e_qall;
        logic [3:0]  e_rd;
        logic        e_vld;
        logic [1:0]  e_ch;
    } vec_t;

    vec_t       vt [14];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         ch_sb [$];
    logic [3:0] rd_sb [$];
    logic [3:0] tbw   [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.set_empty = '0;
        bus.ld_en     = 1'b0;
        bus.ld_ch     = '0;
        bus.ld_d      = '0;
        bus.rd_ch     = '0;
        bus.chg_ack   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tbw[i] = '0;
    endtask

    // Wait for an offer, compare against the scoreboard, hold a cycle, then ack (optionally reloading)
    task automatic serve_one(input bit reload);
        int         t;
        int         exp_ch;
        logic [1:0] ch;
        t = 0;
        while (!bus.chg_valid && t < 20) begin
            step();
            t++;
        end
        if (!bus.chg_valid) begin
            chk("offer_wait", bus.chg_valid, 1);
            if (ch_sb.size() > 0) void'(ch_sb.pop_front());
            return;
        end
        if (ch_sb.size() == 0) begin
            chk("sb_nonempty", ch_sb.size(), 1);
            return;
        end
        exp_ch = ch_sb.pop_front();
        chk("offer_ch", bus.chg_ch, exp_ch);
        ch = bus.chg_ch;
        step();
        chk("offer_hold_vld", bus.chg_valid, 1);
        chk("offer_hold_ch", bus.chg_ch, exp_ch);
        bus.chg_ack = 1'b1;
        if (reload) begin
            bus.ld_en = 1'b1;
            bus.ld_ch = ch;
            bus.ld_d  = tbw[ch] + 4'h1;
            tbw[ch]   = tbw[ch] + 4'h1;
        end
        step();
        bus.chg_ack = 1'b0;
        bus.ld_en   = 1'b0;
        chk("ack_bubble", bus.chg_valid, 0);
    endtask

    initial begin
        // se, ld_en, ld_ch, ld_d, rd_ch, ack | q_all, rd_q, vld, ch
        vt[0]  = '{4'b0101, 1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 16'h0101, 4'h0, 1'b0, 2'd0};
        vt[1]  = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd2, 1'b0, 16'h0101, 4'h1, 1'b1, 2'd0};
        vt[2]  = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd1, 1'b1, 16'h0101, 4'h0, 1'b0, 2'd0};
        vt[3]  = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 16'h0101, 4'h1, 1'b1, 2'd2};
        vt[4]  = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd3, 1'b1, 16'h0101, 4'h0, 1'b0, 2'd0};
        vt[5]  = '{4'b1000, 1'b1, 2'd3, 4'hA, 2'd3, 1'b0, 16'h1101, 4'h0, 1'b0, 2'd0};
        vt[6]  = '{4'b0000, 1'b1, 2'd3, 4'hA, 2'd3, 1'b0, 16'hA101, 4'h1, 1'b1, 2'd3};
        vt[7]  = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd3, 1'b1, 16'hA101, 4'hA, 1'b0, 2'd0};
        vt[8]  = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd2, 1'b0, 16'hA101, 4'h1, 1'b0, 2'd0};
        vt[9]  = '{4'b0000, 1'b1, 2'd1, 4'h5, 2'd1, 1'b0, 16'hA151, 4'h0, 1'b0, 2'd0};
        vt[10] = '{4'b0000, 1'b1, 2'd1, 4'h5, 2'd1, 1'b0, 16'hA151, 4'h5, 1'b1, 2'd1};
        vt[11] = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd0, 1'b1, 16'hA151, 4'h1, 1'b0, 2'd0};
        vt[12] = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd3, 1'b0, 16'hA151, 4'hA, 1'b0, 2'd0};
        vt[13] = '{4'b0000, 1'b0, 2'd0, 4'h0, 2'd2, 1'b0, 16'hA151, 4'h1, 1'b0, 2'd0};

        reset = 1'b1;
        idle_inputs();
        do_reset();

        chk("rst_q_all", bus.q_all, 16'h0000);
        chk("rst_rd_q", bus.rd_q, 4'h0);
        chk("rst_vld", bus.chg_valid, 0);
        chk("rst_ch", bus.chg_ch, 0);

        // Vector table: empty strobes, load/empty collision, identical rewrite
        for (int v = 0; v < 14; v++) begin
            bus.set_empty = vt[v].se;
            bus.ld_en     = vt[v].ld_en;
            bus.ld_ch     = vt[v].ld_ch;
            bus.ld_d      = vt[v].ld_d;
            bus.rd_ch     = vt[v].rd_ch;
            bus.chg_ack   = vt[v].ack;
            rd_sb.push_back(vt[v].e_rd);
            step();
            chk($sformatf("v%0d_q_all", v), bus.q_all, vt[v].e_qall);
            chk($sformatf("v%0d_rd_q", v), bus.rd_q, rd_sb.pop_front());
            chk($sformatf("v%0d_vld", v), bus.chg_valid, vt[v].e_vld);
            if (vt[v].e_vld) chk($sformatf("v%0d_ch", v), bus.chg_ch, vt[v].e_ch);
        end
        idle_inputs();

        // Round-robin fairness: every channel re-changes on its own ack
        do_reset();
        bus.set_empty = 4'b1111;
        step();
        bus.set_empty = 4'b0000;
        for (int i = 0; i < 4; i++) tbw[i] = 4'h1;
        chk("rr_q_all", bus.q_all, 16'h1111);
        ch_sb.push_back(0);
        ch_sb.push_back(1);
        ch_sb.push_back(2);
        ch_sb.push_back(3);
        ch_sb.push_back(0);
        for (int n = 0; n < 5; n++) serve_one(1'b1);

        // Change in the ack cycle keeps the flag: ch2 comes back after ch3
        do_reset();
        bus.ld_en = 1'b1;
        bus.ld_ch = 2'd2;
        bus.ld_d  = 4'h3;
        step();
        bus.ld_ch = 2'd3;
        bus.ld_d  = 4'h4;
        step();
        bus.ld_en = 1'b0;
        tbw[2] = 4'h3;
        tbw[3] = 4'h4;
        ch_sb.push_back(2);
        ch_sb.push_back(3);
        ch_sb.push_back(2);
        serve_one(1'b1);
        serve_one(1'b0);
        serve_one(1'b0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("reoffer_quiet", bus.chg_valid, 0);
        end
        chk("reoffer_q_all", bus.q_all, 16'h4400);
        chk("sb_drained", ch_sb.size(), 0);

        // Asynchronous reset in the middle of an offer
        do_reset();
        bus.set_empty = 4'b0001;
        step();
        bus.set_empty = 4'b0000;
        step();
        chk("pre_arst_vld", bus.chg_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_vld", bus.chg_valid, 0);
        chk("arst_q_all", bus.q_all, 16'h0000);
        chk("arst_rd_q", bus.rd_q, 4'h0);
        #2;
        reset = 1'b0;
        step();
        chk("post_arst_vld", bus.chg_valid, 0);
        step();
        chk("post_arst_idle", bus.chg_valid, 0);
        bus.set_empty = 4'b1010;
        step();
        bus.set_empty = 4'b0000;
        chk("post_arst_q_all", bus.q_all, 16'h1010);
        step();
        chk("post_arst_offer_vld", bus.chg_valid, 1);
        chk("post_arst_offer_ch", bus.chg_ch, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/l4_status_regfile.md
# L4_status_regfile

Parametrised multi-channel status register file for the 32x32 PCI switch datapath. Holds one NBITS status word per channel and supports per-channel force-to-empty plus an addressed load port. It tracks which channels have changed value since they were last reported. A round-robin change reporter offers one changed channel at a time to the controller over a valid/ack handshake.

## Interface
- NBITS, 4, width of each channel status word
- NCH, 4, number of channels (2..32)
- CHW, 2, channel index width; must satisfy 2**CHW >= NCH
- EMPTY_VAL, 1, status code written by set_empty (NBITS wide)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- set_empty  input  NCH  per-channel force-to-EMPTY_VAL
- ld_en  input  1  load strobe
- ld_ch  input  CHW  load target channel
- ld_d  input  NBITS  load data
- rd_ch  input  CHW  read-port channel select
- rd_q  output  NBITS  registered read data
- q_all  output  NCH*NBITS  all status words; channel i at bits [i*NBITS +: NBITS]
- chg_valid  output  1  a changed channel is being offered
- chg_ch  output  CHW  offered channel index
- chg_ack  input  1  controller accepts the offered channel

## Operation
- Per-channel update priority:
  - reset (all words 0)
  - then set_empty[i] (word becomes EMPTY_VAL)
  - then ld_en && ld_ch==i (word becomes ld_d)
  - otherwise the word holds.
- ld_en with ld_ch >= NCH is ignored; no state changes.
- set_empty on several channels in the same cycle is legal; all take effect.
- A load to channel i in the same cycle as set_empty[i] is dropped.
- Change flag chg_flag[i] is set on any edge where word i's next value differs from its current value.
  - Rewriting an identical value does not set it.
  - Reset value 0 differs from EMPTY_VAL, so set_empty after reset is a change.
- q_all is the registered words directly (no extra delay).
- rd_q <= word[rd_ch] (pre-update value at that edge). rd_ch >= NCH returns 0.
- Change reporter FSM, states IDLE and OFFER; rotating pointer ptr (CHW bits, range 0..NCH-1):
  - IDLE: if any chg_flag is set, latch chg_ch = first set flag searching ptr, ptr+1, ... mod NCH. Go to OFFER with chg_valid=1. Otherwise stay in IDLE, chg_valid=0.
  - OFFER: chg_valid=1 and chg_ch stay stable until chg_ack.
  - OFFER on chg_ack: clear chg_flag[chg_ch], ptr <= (chg_ch+1) mod NCH, go to IDLE, chg_valid=0.
  - If channel chg_ch changes again in the ack cycle, its flag stays set (set wins over clear).
  - chg_ack while in IDLE is ignored.
- Reset mid-offer: FSM returns to IDLE; all flags, words and ptr are cleared.

## Timing
- Reset values:
  - all words 0
  - q_all 0, rd_q 0
  - chg_flag all 0
  - ptr 0
  - chg_valid 0, chg_ch 0
  - FSM in IDLE
- Load/set_empty: word is visible on q_all one cycle after the strobe edge.
- Read: rd_q valid one cycle after rd_ch is presented.
- Change reporting:
  - Earliest chg_valid is 2 edges after the changing update: flag set on edge 1, OFFER on edge 2.
  - After an ack, chg_valid is low for exactly one cycle (IDLE bubble) before the next offer.
  - Sustained throughput is one report per 2 cycles.
- With N channels permanently changing, each is offered at least once in every 2N cycles (round-robin fairness).

## Test plan
- Reset, then check outputs:
  - every output is 0 and chg_valid=0
  - pulse set_empty=4'b0101 -> q_all=16'h0101 after 1 cycle
  - chg_valid rises 2 cycles after the strobe with chg_ch=0
  - ack -> chg_ch=2 offered after the 1-cycle bubble.
- ld_en=1, ld_ch=3, ld_d=4'hA with set_empty[3]=1 in the same cycle -> word3=EMPTY_VAL. Then ld_d=4'hA alone -> word3=4'hA, flag set.
- Load word1=4'h5 twice; ack the first report -> no second report, because the identical rewrite makes no change.
- Flags on channels 0..3 set and re-set on every ack -> offers go 0,1,2,3,0 in that order.
- While in OFFER for ch2, load ch2 with a new value in the ack cycle -> ch2 re-offered after ch3 has been served.
- Assert reset asynchronously mid-OFFER (between edges) -> chg_valid and q_all go 0 immediately, without waiting for a clock edge; after release the FSM is in IDLE.
